digit_sequencer: RTL and testbench
==================================

// Module: digit_sequencer
// PURPOSE
//  Buffers a keylock code entered one digit at a time and streams it, digit by digit,
//  into the Arduino sender stage over its enabled/done handshake.
//  Sits directly upstream of the sender. Drives the sender's num/enabled inputs and
//  consumes its done output. Inserts an idle gap between digits so that the sender
//  resets its counter and done flag before the next digit.
// PARAMETERS
//  DEPTH   8        max digits buffered (FIFO entries); power of two, >=2
//  GAP     1200000  hwclk cycles send_enabled is held low between digits (>=1)
//  CW      32       width of gap counter
// PORTS
//  hwclk         in   1    system clock; all logic on posedge
//  rst_n         in   1    synchronous, active-low reset
//  push          in   1    write push_num into FIFO this cycle
//  push_num      in   4    digit to buffer (0..15 accepted; sender zeroes lines for >=7)
//  start         in   1    begin transmitting buffered digits
//  full          out  1    FIFO holds DEPTH digits
//  count         out  $clog2(DEPTH)+1  digits currently buffered
//  busy          out  1    sequence in progress
//  seq_done      out  1    one-cycle pulse when last digit (and terminator) finished
//  send_num      out  4    digit to sender (num)
//  send_enabled  out  1    sender enable
//  send_done     in   1    sender done flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): FIFO emptied, FSM->IDLE, gap counter 0; full=0, count=0,
//   busy=0, seq_done=0, send_num=0, send_enabled=0. This applies mid-sequence too:
//   send_enabled drops at the next edge and the rest of the code is discarded.
//  FIFO: push && !full writes at the edge; push when full is ignored (no overwrite).
//   Pushes are accepted in every state. A digit pushed during busy is sent in the same run.
//   Pointers wrap mod DEPTH. count = writes - pops.
//  FSM states: IDLE, SEND, GAP_WAIT, TERM_SEND, TERM_GAP.
//   IDLE: start && count!=0 -> SEND; send_num<=head, send_enabled<=1, busy<=1 (latency 1).
//         start && count==0 is ignored (no busy, no seq_done).
//   SEND: hold send_num/send_enabled. On send_done==1: send_enabled<=0, pop head,
//         gap counter<=0 -> GAP_WAIT.
//   GAP_WAIT: send_enabled=0. Increment the counter each cycle. At counter==GAP-1:
//         if FIFO not empty -> SEND with the new head (enabled re-asserts).
//         Else, if TERMINATOR_EN -> TERM_SEND; otherwise -> IDLE with busy<=0 and
//         seq_done<=1 for one cycle.
//   start while busy is ignored. A push and a pop in the same cycle are both honoured;
//   count stays unchanged.
//  send_enabled is low for exactly GAP cycles between digits. send_num changes only
//   while send_enabled is low or on the edge where it rises.
// CONFIGURATION
//  TERMINATOR_EN defined: after the last buffered digit's gap, send digit 7 (the sender
//   drives all data lines 0 with a control strobe) as an end-of-code marker. The marker
//   uses the TERM_SEND/TERM_GAP states with the same done/gap rules. seq_done pulses at
//   the end of TERM_GAP.
//  Undefined: the TERM_* states are not built; seq_done follows the last real digit's gap.
// TESTING (GAP=4, DEPTH=4, sender model asserts done 3 cycles after enabled and clears
//   it when enabled is low)
//  1 Push 3,1,5; pulse start -> send_num 3,1,5 in order. Each digit has enabled high
//    until done, then 4 low cycles. seq_done pulses once, then busy=0 and count=0.
//  2 Push 5 digits with no start -> full=1 after the 4th, the 5th is dropped,
//    count=4, and only the first 4 are sent.
//  3 Start with an empty FIFO -> busy remains 0, send_enabled remains 0, no seq_done.
//  4 Push 2 during SEND of a 1-digit run -> 2 is sent after the gap; a single
//    seq_done follows after both digits.
//  5 Assert rst_n=0 while send_enabled=1 on digit 2 of 3 -> at the next edge all
//    outputs=0 and count=0. A subsequent start is ignored.
//  6 With TERMINATOR_EN, push 4; start -> send_num 4 then 7. seq_done pulses after
//    the 7's gap; without the macro, no 7 is sent.

Source files
------------

// File: rtl/digit_sequencer.sv
// Keylock digit buffer and sequencer feeding the Arduino sender handshake.
// Optional end-of-code marker (digit 7) built when TERMINATOR_EN is defined.
module digit_sequencer #(
    parameter int DEPTH = 8,
    parameter int GAP   = 1200000,
    parameter int CW    = 32
) (
    input  logic                   hwclk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [3:0]             push_num,
    input  logic                   start,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   seq_done,
    output logic [3:0]             send_num,
    output logic                   send_enabled,
    input  logic                   send_done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEND  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
`ifdef TERMINATOR_EN
    localparam logic [2:0] S_TSEND = 3'd3;
    localparam logic [2:0] S_TGAP  = 3'd4;
`endif

    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CNTW-1:0] r_count;
    logic [2:0]      r_state;
    logic [CW-1:0]   r_gap;
    logic            r_busy;
    logic            r_seq_done;
    logic [3:0]      r_send_num;
    logic            r_send_en;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_gap_end;
    logic [3:0]      w_head;

    assign w_full    = (r_count == CNTW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = push && !w_full;
    assign w_pop     = (r_state == S_SEND) && send_done;
    assign w_gap_end = (r_gap == CW'(GAP - 1));
    assign w_head    = r_mem[r_rptr];

    assign full         = w_full;
    assign count        = r_count;
    assign busy         = r_busy;
    assign seq_done     = r_seq_done;
    assign send_num     = r_send_num;
    assign send_enabled = r_send_en;

    // FIFO storage; contents need no reset, the pointers define validity
    always_ff @(posedge hwclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= push_num;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep count
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
        end
    end

    // Sequencer: one digit per enabled/done handshake, GAP low cycles between
    always_ff @(posedge hwclk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_gap      <= '0;
            r_busy     <= 1'b0;
            r_seq_done <= 1'b0;
            r_send_num <= 4'd0;
            r_send_en  <= 1'b0;
        end else begin
            r_seq_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start && !w_empty) begin
                        r_send_num <= w_head;
                        r_send_en  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (send_done) begin
                        r_send_en <= 1'b0;
                        r_gap     <= '0;
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + CW'(1);
                    if (w_gap_end) begin
                        if (!w_empty) begin
                            r_send_num <= w_head;
                            r_send_en  <= 1'b1;
                            r_state    <= S_SEND;
                        end else begin
`ifdef TERMINATOR_EN
                            r_send_num <= 4'd7;
                            r_send_en  <= 1'b1;
                            r_state    <= S_TSEND;
`else
                            r_busy     <= 1'b0;
                            r_seq_done <= 1'b1;
                            r_state    <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef TERMINATOR_EN
                S_TSEND: begin
                    if (send_done) begin
                        r_send_en <= 1'b0;
                        r_gap     <= '0;
                        r_state   <= S_TGAP;
                    end
                end
                S_TGAP: begin
                    r_gap <= r_gap + CW'(1);
                    if (w_gap_end) begin
                        r_busy     <= 1'b0;
                        r_seq_done <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                end
`endif
                default: begin
                    r_send_en <= 1'b0;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_sequencer.sv
// Scoreboard bench for digit_sequencer with GAP=4, DEPTH=4 and a sender model.
// Expected digits/seq_done markers are queued by stimulus, checked by a monitor.
module tb_digit_sequencer;

    localparam int DEPTH = 4;
    localparam int GAP   = 4;
    localparam int MARK  = 100;

    logic       hwclk = 1'b0;
    logic       rst_n;
    logic       push;
    logic [3:0] push_num;
    logic       start;
    logic       full;
    logic [2:0] count;
    logic       busy;
    logic       seq_done;
    logic [3:0] send_num;
    logic       send_enabled;
    logic       send_done;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int rise_cnt = 0;
    int low_cnt  = 0;
    bit had_prev = 0;
    bit prev_en  = 0;
    int snd_cnt  = 0;

    digit_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .CW(32)) dut (
        .hwclk(hwclk), .rst_n(rst_n), .push(push), .push_num(push_num),
        .start(start), .full(full), .count(count), .busy(busy),
        .seq_done(seq_done), .send_num(send_num),
        .send_enabled(send_enabled), .send_done(send_done)
    );

    always #5 hwclk = ~hwclk;

    // Sender model: done rises 3 cycles after enabled, clears when enabled low
    always @(posedge hwclk) begin
        if (!send_enabled) begin
            snd_cnt   <= 0;
            send_done <= 1'b0;
        end else if (snd_cnt == 2) begin
            send_done <= 1'b1;
        end else begin
            snd_cnt <= snd_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: pops expectations on each enabled rise and each seq_done
    always @(negedge hwclk) begin
        int e;
        if (seq_done) begin
            if (exp_q.size() == 0) begin
                check("seq_done_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("seq_done_order", MARK, e);
            end
        end
        if (send_enabled && !prev_en) begin
            rise_cnt++;
            if (exp_q.size() == 0) begin
                check("digit_unexpected", int'(send_num), -1);
            end else begin
                e = exp_q.pop_front();
                check("digit", int'(send_num), e);
            end
            if (had_prev) check("gap_len", low_cnt, GAP);
            had_prev = 1;
            low_cnt  = 0;
        end else if (busy && !send_enabled) begin
            low_cnt++;
        end
        if (!busy) begin
            had_prev = 0;
            low_cnt  = 0;
        end
        prev_en = send_enabled;
    end

    task automatic push_d(input int d, input bit accept);
        @(negedge hwclk);
        push     = 1'b1;
        push_num = 4'(d);
        if (accept) exp_q.push_back(d);
        @(negedge hwclk);
        push = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge hwclk);
        start = 1'b1;
        @(negedge hwclk);
        start = 1'b0;
    endtask

    task automatic end_marks();
`ifdef TERMINATOR_EN
        exp_q.push_back(7);
`endif
        exp_q.push_back(MARK);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge hwclk);
            n++;
        end
        check({name, "_timeout"}, int'(n >= 500), 0);
        repeat (2) @(negedge hwclk);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_count"}, int'(count), 0);
        check({name, "_q_left"}, exp_q.size(), 0);
    endtask

    task automatic wait_rises(input int target);
        int n = 0;
        while (rise_cnt < target && n < 500) begin
            @(negedge hwclk);
            n++;
        end
        check("rise_timeout", int'(n >= 500), 0);
    endtask

    initial begin
        int base;
        rst_n    = 1'b0;
        push     = 1'b0;
        push_num = 4'd0;
        start    = 1'b0;
        repeat (3) @(negedge hwclk);
        check("rst_full", int'(full), 0);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_en", int'(send_enabled), 0);
        check("rst_num", int'(send_num), 0);
        rst_n = 1'b1;

        // 1: basic three-digit code
        push_d(3, 1);
        push_d(1, 1);
        push_d(5, 1);
        check("t1_count", int'(count), 3);
        pulse_start();
        check("t1_busy", int'(busy), 1);
        end_marks();
        wait_idle("t1");

        // 2: overflow drops the fifth digit
        push_d(9, 1);
        push_d(2, 1);
        push_d(6, 1);
        check("t2_notfull", int'(full), 0);
        push_d(4, 1);
        check("t2_full", int'(full), 1);
        push_d(8, 0);
        check("t2_count", int'(count), 4);
        check("t2_full2", int'(full), 1);
        pulse_start();
        end_marks();
        wait_idle("t2");
        check("t2_full_after", int'(full), 0);

        // 3: start with empty FIFO is ignored
        pulse_start();
        repeat (6) begin
            @(negedge hwclk);
            check("t3_busy", int'(busy), 0);
            check("t3_en", int'(send_enabled), 0);
        end

        // 4: digit pushed mid-run joins the same run
        push_d(1, 1);
        base = rise_cnt;
        pulse_start();
        wait_rises(base + 1);
        push_d(2, 1);
        end_marks();
        wait_idle("t4");

        // 5: reset during second digit discards the rest
        push_d(3, 1);
        push_d(1, 1);
        push_d(5, 1);
        base = rise_cnt;
        pulse_start();
        wait_rises(base + 2);
        check("t5_en_before", int'(send_enabled), 1);
        rst_n = 1'b0;
        @(negedge hwclk);
        exp_q.delete();
        check("t5_en", int'(send_enabled), 0);
        check("t5_num", int'(send_num), 0);
        check("t5_busy", int'(busy), 0);
        check("t5_count", int'(count), 0);
        check("t5_full", int'(full), 0);
        check("t5_done", int'(seq_done), 0);
        rst_n = 1'b1;
        pulse_start();
        repeat (4) begin
            @(negedge hwclk);
            check("t5_busy_after", int'(busy), 0);
        end

        // 6: single digit; terminator follows only when built in
        push_d(4, 1);
        pulse_start();
        end_marks();
        wait_idle("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
